// File: rtl/conv_pool_reader.sv
// 2x2 stride-2 max-pool reader over a held IDim x IDim feature map, streaming pooled values out on valid/ready.
// Optional build macro CONV_POOL_RELU_EN clamps negative pooled values to zero at the output register.
module conv_pool_reader #(
  parameter int IDim       = 28,
  parameter int PDim       = 14,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] Fmap [IDim][IDim],
  output logic [DATA_WIDTH-1:0] pool_data,
  output logic [IDX_WIDTH-1:0]  pool_row,
  output logic [IDX_WIDTH-1:0]  pool_col,
  output logic                  pool_valid,
  input  logic                  pool_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, READ, EMIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  r_q, r_d, c_q, c_d;
  logic [2:0]            k_q, k_d;      // next element to fetch (4 = all fetched)
  logic [1:0]            ek_q, ek_d;    // element index currently held in elem_q
  logic                  ev_q, ev_d;    // elem_q holds an unconsumed element
  logic [DATA_WIDTH-1:0] elem_q, elem_d, max_q, max_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_WIDTH-1:0]  row_q, row_d, col_q, col_d;
  logic                  valid_q, valid_d, done_q, done_d;

  logic                  fetch_en;
  logic [IDX_WIDTH-1:0]  fr, fc, r_nxt, c_nxt;
  logic [1:0]            fk;
  logic [IDX_WIDTH:0]    frow, fcol;
  logic                  last_win;
  logic [DATA_WIDTH-1:0] cand, result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      ek_q    <= '0;
      ev_q    <= 1'b0;
      elem_q  <= '0;
      max_q   <= '0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      ek_q    <= ek_d;
      ev_q    <= ev_d;
      elem_q  <= elem_d;
      max_q   <= max_d;
      data_q  <= data_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    k_d      = k_q;
    ek_d     = ek_q;
    ev_d     = 1'b0;
    max_d    = max_q;
    data_d   = data_q;
    row_d    = row_q;
    col_d    = col_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    fetch_en = 1'b0;
    fr       = r_q;
    fc       = c_q;
    fk       = k_q[1:0];

    cand = (ek_q == 2'd0) ? elem_q
         : (($signed(elem_q) > $signed(max_q)) ? elem_q : max_q);
`ifdef CONV_POOL_RELU_EN
    result = cand[DATA_WIDTH-1] ? '0 : cand;
`else
    result = cand;
`endif

    last_win = (r_q == IDX_WIDTH'(PDim-1)) && (c_q == IDX_WIDTH'(PDim-1));
    if (c_q == IDX_WIDTH'(PDim-1)) begin
      c_nxt = '0;
      r_nxt = r_q + 1'b1;
    end else begin
      c_nxt = c_q + 1'b1;
      r_nxt = r_q;
    end

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (!start) begin
          state_d = IDLE;
          valid_d = 1'b0;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
        end else begin
          // Fetch is one cycle ahead of the compare (registered read).
          if (k_q < 3'd4) begin
            fetch_en = 1'b1;
            ek_d     = k_q[1:0];
            ev_d     = 1'b1;
            k_d      = k_q + 3'd1;
          end
          if (ev_q) begin
            max_d = cand;
            if (ek_q == 2'd3) begin
              data_d  = result;
              row_d   = r_q;
              col_d   = c_q;
              valid_d = 1'b1;
              state_d = EMIT;
            end
          end
        end
      end
      EMIT: begin
        if (!start) begin
          state_d = IDLE;
          valid_d = 1'b0;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
        end else if (pool_ready) begin
          valid_d = 1'b0;
          if (last_win) begin
            state_d = DONE;
            done_d  = 1'b1;
            r_d     = '0;
            c_d     = '0;
            k_d     = '0;
          end else begin
            // Prefetch element 0 of the next window on the accepting edge.
            r_d      = r_nxt;
            c_d      = c_nxt;
            fetch_en = 1'b1;
            fr       = r_nxt;
            fc       = c_nxt;
            fk       = 2'd0;
            ek_d     = 2'd0;
            ev_d     = 1'b1;
            k_d      = 3'd1;
            state_d  = READ;
          end
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    frow   = {fr, fk[1]};
    fcol   = {fc, fk[0]};
    elem_d = fetch_en ? Fmap[frow][fcol] : elem_q;
  end

  assign pool_data  = data_q;
  assign pool_row   = row_q;
  assign pool_col   = col_q;
  assign pool_valid = valid_q;
  assign done       = done_q;
  assign busy       = (state_q == READ) || (state_q == EMIT);

endmodule

// File: tb/tb_conv_pool_reader.sv
// Directed bench for conv_pool_reader: full-map runs checked against a hand-computed vector table,
// plus stall, abort and mid-run reset sequences.
module tb_conv_pool_reader;
  localparam int IDIM = 28;
  localparam int PDIM = 14;
  localparam int DW   = 32;
  localparam int IW   = 4;

`ifdef CONV_POOL_RELU_EN
  localparam logic [31:0] E_NEG2  = 32'h0;
  localparam logic [31:0] E_NEG4  = 32'h0;
  localparam logic [31:0] E_NEG16 = 32'h0;
`else
  localparam logic [31:0] E_NEG2  = 32'hFFFF_FFFE;
  localparam logic [31:0] E_NEG4  = 32'hFFFF_FFFC;
  localparam logic [31:0] E_NEG16 = 32'hFFFF_FFF0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, pool_ready;
  logic [DW-1:0] fmap [IDIM][IDIM];
  logic [DW-1:0] pool_data;
  logic [IW-1:0] pool_row, pool_col;
  logic          pool_valid, busy, done;

  always #5 clk = ~clk;

  conv_pool_reader #(.IDim(IDIM), .PDim(PDIM), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .Fmap       (fmap),
    .pool_data  (pool_data),
    .pool_row   (pool_row),
    .pool_col   (pool_col),
    .pool_valid (pool_valid),
    .pool_ready (pool_ready),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int          pid;
    int          r;
    int          c;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] cap [4][PDIM][PDIM];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pattern(input int pid);
    for (int i = 0; i < IDIM; i++)
      for (int j = 0; j < IDIM; j++)
        fmap[i][j] = (pid == 1) ? 32'(i * IDIM + j) : 32'h0;
    case (pid)
      0: fmap[3][5] = 32'd77;
      2: begin
        fmap[0][0] = 32'hFFFF_FFFB; fmap[0][1] = 32'hFFFF_FFFE;
        fmap[1][0] = 32'hFFFF_FFF7; fmap[1][1] = 32'hFFFF_FFFD;
      end
      3: begin
        fmap[0][0] = 32'd3;         fmap[0][1] = 32'hFFFF_FFFF;
        fmap[1][0] = 32'd2;         fmap[1][1] = 32'd1;
        fmap[0][2] = 32'hFFFF_FFF8; fmap[0][3] = 32'hFFFF_FFFC;
        fmap[1][2] = 32'hFFFF_FFFA; fmap[1][3] = 32'hFFFF_FFF9;
        fmap[0][4] = 32'd5;         fmap[0][5] = 32'd9;
        fmap[1][4] = 32'hFFFF_FF9C; fmap[1][5] = 32'd9;
        fmap[0][6] = 32'hFFFF_FFF0; fmap[0][7] = 32'hFFFF_FFF0;
        fmap[1][6] = 32'hFFFF_FFF0; fmap[1][7] = 32'hFFFF_FFF0;
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Returns the number of edges until the given window is presented as valid.
  task automatic wait_win(input int r, input int c, input int budget, output int edges);
    edges = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (pool_valid && int'(pool_row) == r && int'(pool_col) == c) begin
        edges = i;
        break;
      end
    end
    if (edges == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_win(%0d,%0d): no valid within %0d cycles", r, c, budget);
    end
  endtask

  task automatic run_full(input int pid);
    int hs, dcount, dedge;
    hs = 0; dcount = 0; dedge = -1;
    set_pattern(pid);
    do_reset();
    pool_ready = 1'b1;
    start      = 1'b1;
    tick();
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int e = 1; e <= 1000; e++) begin
      tick();
      if (pool_valid) begin
        chk("valid_edge", 32'(e), 32'(5 + 5 * hs));
        chk("raster_row", 32'(pool_row), 32'(hs / PDIM));
        chk("raster_col", 32'(pool_col), 32'(hs % PDIM));
        if (int'(pool_row) < PDIM && int'(pool_col) < PDIM)
          cap[pid][pool_row][pool_col] = pool_data;
        hs++;
      end
      if (done) begin
        dcount++;
        dedge = e;
        chk("busy_in_done", 32'(busy), 32'd0);
      end
    end
    $display("run pid=%0d handshakes=%0d done_count=%0d done_edge=%0d", pid, hs, dcount, dedge);
    chk("handshakes", 32'(hs), 32'd196);
    chk("done_count", 32'(dcount), 32'd1);
    chk("done_edge", 32'(dedge), 32'd981);
    start = 1'b0;
    tick();
  endtask

  initial begin
    int e;
    bit saw_done;

    vecs[0]  = '{0, 1, 2, 32'd77};
    vecs[1]  = '{0, 0, 0, 32'd0};
    vecs[2]  = '{0, 1, 3, 32'd0};
    vecs[3]  = '{0, 13, 13, 32'd0};
    vecs[4]  = '{1, 0, 0, 32'd29};
    vecs[5]  = '{1, 1, 2, 32'd89};
    vecs[6]  = '{1, 4, 7, 32'd267};
    vecs[7]  = '{1, 6, 0, 32'd365};
    vecs[8]  = '{1, 13, 13, 32'd783};
    vecs[9]  = '{2, 0, 0, E_NEG2};
    vecs[10] = '{2, 0, 1, 32'd0};
    vecs[11] = '{3, 0, 0, 32'd3};
    vecs[12] = '{3, 0, 1, E_NEG4};
    vecs[13] = '{3, 0, 2, 32'd9};
    vecs[14] = '{3, 0, 3, E_NEG16};
    vecs[15] = '{3, 1, 0, 32'd0};

    for (int p = 0; p < 4; p++)
      for (int r = 0; r < PDIM; r++)
        for (int c = 0; c < PDIM; c++)
          cap[p][r][c] = 32'hDEAD_BEEF;

    pool_ready = 1'b0;
    set_pattern(1);
    do_reset();
    chk("rst_data", pool_data, 32'd0);
    chk("rst_row", 32'(pool_row), 32'd0);
    chk("rst_col", 32'(pool_col), 32'd0);
    chk("rst_valid", 32'(pool_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    for (int p = 0; p < 4; p++) run_full(p);

    for (int v = 0; v < 16; v++) begin
      $display("vec %0d pid=%0d win=(%0d,%0d) data=%h exp=%h", v, vecs[v].pid, vecs[v].r,
               vecs[v].c, cap[vecs[v].pid][vecs[v].r][vecs[v].c], vecs[v].exp);
      chk("vec_data", cap[vecs[v].pid][vecs[v].r][vecs[v].c], vecs[v].exp);
    end

    // Backpressure on window (0,0)
    set_pattern(1);
    do_reset();
    pool_ready = 1'b0;
    start      = 1'b1;
    tick();
    wait_win(0, 0, 20, e);
    chk("stall_first_valid_edge", 32'(e), 32'd5);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", 32'(pool_valid), 32'd1);
      chk("stall_data", pool_data, 32'd29);
      chk("stall_row", 32'(pool_row), 32'd0);
      chk("stall_col", 32'(pool_col), 32'd0);
    end
    $display("stall: held 10 cycles, raising ready");
    pool_ready = 1'b1;
    tick();
    chk("stall_accept_clears_valid", 32'(pool_valid), 32'd0);
    wait_win(0, 1, 20, e);
    chk("stall_next_valid_delay", 32'(e), 32'd4);
    chk("stall_next_data", pool_data, 32'd31);

    // Abort during READ of window (4,7)
    set_pattern(1);
    do_reset();
    pool_ready = 1'b1;
    start      = 1'b1;
    tick();
    wait_win(4, 6, 400, e);
    chk("abort_pre_edge", 32'(e), 32'd315);
    tick();
    tick();
    chk("abort_busy_before", 32'(busy), 32'd1);
    chk("abort_valid_before", 32'(pool_valid), 32'd0);
    start = 1'b0;
    tick();
    $display("abort: start dropped in READ of (4,7)");
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(pool_valid), 32'd0);
    saw_done = done;
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_done |= done;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    start = 1'b1;
    tick();
    wait_win(0, 0, 20, e);
    chk("abort_restart_edge", 32'(e), 32'd5);
    chk("abort_restart_data", pool_data, 32'd29);

    // Reset pulse while holding window (1,2) in EMIT
    set_pattern(1);
    do_reset();
    pool_ready = 1'b1;
    start      = 1'b1;
    tick();
    wait_win(1, 2, 200, e);
    pool_ready = 1'b0;
    tick();
    chk("mid_hold_data", pool_data, 32'd89);
    rst_n = 1'b0;
    tick();
    $display("midreset: rst_n pulsed during EMIT of (1,2)");
    chk("midrst_data", pool_data, 32'd0);
    chk("midrst_row", 32'(pool_row), 32'd0);
    chk("midrst_col", 32'(pool_col), 32'd0);
    chk("midrst_valid", 32'(pool_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    rst_n      = 1'b1;
    pool_ready = 1'b1;
    tick();
    chk("midrst_restart_busy", 32'(busy), 32'd1);
    wait_win(0, 0, 20, e);
    chk("midrst_restart_edge", 32'(e), 32'd5);
    chk("midrst_restart_data", pool_data, 32'd29);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
